// File: rtl/rtc_bus_responder.sv
// Bus-mapped packed-BCD real-time clock with pending, live and snapshot banks behind synchronized strobes.
// Optional countdown timer, F2 commit and irq are built only with RTC_RESP_TIMER_EN defined.
module rtc_bus_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick_1hz,
  input  logic       i_cs,
  input  logic       i_rd,
  input  logic       i_wr,
  input  logic       i_a_d,
  input  logic [7:0] i_bus_in,
  output logic [7:0] o_bus_out,
  output logic       o_bus_oe,
  output logic       o_irq
);
  typedef struct packed { logic [7:0] anio, mes, dia, hora, min, seg; } time_t;
  localparam time_t TIME_RST = '{anio: 8'h00, mes: 8'h01, dia: 8'h01, hora: 8'h00, min: 8'h00, seg: 8'h00};

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim, input logic [7:0] base);
    if (v >= lim)              return base;
    else if (v[3:0] >= 4'h9)   return {v[7:4] + 4'h1, 4'h0};
    else                       return v + 8'h01;
  endfunction

  function automatic logic [7:0] month_days(input logic [7:0] mes, input logic [7:0] anio);
    logic [7:0] dec;
    dec = 8'(anio[7:4]) * 8'd10 + 8'(anio[3:0]);
    case (mes)
      8'h02:                      return (dec[1:0] == 2'b00) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [SYNC_STAGES-1:0]      r_sync_vld;
  logic w_cs, w_rd, w_wr, w_a_d, w_vld;
  logic r_wr_hi, r_wr_arm;
  logic w_wr_evt, w_addr_wr, w_data_wr, w_cmd_f0, w_cmd_f1, w_st0_wr, w_st2_wr;
  logic w_rd_act, w_expire;
  logic [7:0] r_addr, r_st0, r_st1, r_st2, w_rd_data, r_bus_out;
  logic r_bus_oe;
  time_t r_live, r_pend, r_snap, w_live_inc;
  logic w_c_seg, w_c_min, w_c_hora, w_c_dia;

  assign {w_cs, w_rd, w_wr, w_a_d} = r_sync[SYNC_STAGES-1];
  // r_sync_vld marks when the synchronizer output reflects the pin rather than its reset fill
  assign w_vld     = r_sync_vld[SYNC_STAGES-1];
  assign w_wr_evt  = r_wr_arm & w_wr & ~w_cs;
  assign w_addr_wr = w_wr_evt & ~w_a_d;
  assign w_data_wr = w_wr_evt & w_a_d;
  assign w_cmd_f0  = w_data_wr & (r_addr == 8'hF0);
  assign w_cmd_f1  = w_data_wr & (r_addr == 8'hF1);
  assign w_st0_wr  = w_data_wr & (r_addr == 8'h00);
  assign w_st2_wr  = w_data_wr & (r_addr == 8'h02);
  assign w_rd_act  = ~w_cs & ~w_rd & w_a_d;

  always_comb begin
    w_live_inc = r_live;
    w_c_seg  = r_live.seg >= 8'h59;
    w_c_min  = w_c_seg  & (r_live.min  >= 8'h59);
    w_c_hora = w_c_min  & (r_live.hora >= 8'h23);
    w_c_dia  = w_c_hora & (r_live.dia  >= month_days(r_live.mes, r_live.anio));
    w_live_inc.seg = bcd_inc(r_live.seg, 8'h59, 8'h00);
    if (w_c_seg)  w_live_inc.min  = bcd_inc(r_live.min, 8'h59, 8'h00);
    if (w_c_min)  w_live_inc.hora = bcd_inc(r_live.hora, 8'h23, 8'h00);
    if (w_c_hora) w_live_inc.dia  = bcd_inc(r_live.dia, month_days(r_live.mes, r_live.anio), 8'h01);
    if (w_c_dia)  w_live_inc.mes  = bcd_inc(r_live.mes, 8'h12, 8'h01);
    if (w_c_dia && r_live.mes >= 8'h12) w_live_inc.anio = bcd_inc(r_live.anio, 8'h99, 8'h00);
  end

`ifdef RTC_RESP_TIMER_EN
  typedef struct packed { logic [7:0] thora, tmin, tseg; } timer_t;
  timer_t r_tlive, r_tpend, r_tsnap, w_tdec;
  logic w_cmd_f2, w_tcount;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    else                return v - 8'h01;
  endfunction

  always_comb begin
    w_tdec = r_tlive;
    w_tdec.tseg = (r_tlive.tseg == 8'h00) ? 8'h59 : bcd_dec(r_tlive.tseg);
    if (r_tlive.tseg == 8'h00) begin
      w_tdec.tmin = (r_tlive.tmin == 8'h00) ? 8'h59 : bcd_dec(r_tlive.tmin);
      if (r_tlive.tmin == 8'h00) w_tdec.thora = bcd_dec(r_tlive.thora);
    end
  end

  // a commit in the same clk drops this tick for the timer bank only
  assign w_cmd_f2 = w_data_wr & (r_addr == 8'hF2);
  assign w_tcount = i_tick_1hz & r_st2[0] & (r_tlive != '0) & ~w_cmd_f2;
  assign w_expire = w_tcount & (w_tdec == '0);
  assign o_irq    = r_st0[2];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_tlive <= '0;
      r_tpend <= '0;
      r_tsnap <= '0;
    end else begin
      if (w_cmd_f2)      r_tlive <= r_tpend;
      else if (w_tcount) r_tlive <= w_tdec;
      if (w_cmd_f0) r_tsnap <= r_tlive;
      if (w_data_wr) begin
        case (r_addr)
          8'h41:   r_tpend.tseg  <= i_bus_in;
          8'h42:   r_tpend.tmin  <= i_bus_in;
          8'h43:   r_tpend.thora <= i_bus_in;
          default: ;
        endcase
      end
    end
  end
`else
  assign w_expire = 1'b0;
  assign o_irq    = 1'b0;
`endif

  always_comb begin
    w_rd_data = 8'h00;
    case (r_addr)
      8'h00:   w_rd_data = r_st0;
      8'h01:   w_rd_data = r_st1;
      8'h02:   w_rd_data = r_st2;
      8'h21:   w_rd_data = r_snap.seg;
      8'h22:   w_rd_data = r_snap.min;
      8'h23:   w_rd_data = r_snap.hora;
      8'h24:   w_rd_data = r_snap.dia;
      8'h25:   w_rd_data = r_snap.mes;
      8'h26:   w_rd_data = r_snap.anio;
`ifdef RTC_RESP_TIMER_EN
      8'h41:   w_rd_data = r_tsnap.tseg;
      8'h42:   w_rd_data = r_tsnap.tmin;
      8'h43:   w_rd_data = r_tsnap.thora;
`endif
      default: w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync     <= '1;
      r_sync_vld <= '0;
      r_wr_hi    <= 1'b0;
      r_wr_arm   <= 1'b0;
      r_addr     <= 8'h00;
      r_st0      <= 8'h00;
      r_st1      <= 8'h00;
      r_st2      <= 8'h00;
      r_live     <= TIME_RST;
      r_pend     <= TIME_RST;
      r_snap     <= TIME_RST;
      r_bus_oe   <= 1'b0;
      r_bus_out  <= 8'h00;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], {i_cs, i_rd, i_wr, i_a_d}};
      r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
      if (w_vld && w_wr) r_wr_hi <= 1'b1;
      if (w_wr)                  r_wr_arm <= 1'b0;
      else if (w_vld && r_wr_hi) r_wr_arm <= 1'b1;
      if (w_addr_wr) r_addr <= i_bus_in;
      if (w_cmd_f1)        r_live <= r_pend;
      else if (i_tick_1hz) r_live <= w_live_inc;
      if (w_cmd_f0) r_snap <= r_live;
      if (w_data_wr) begin
        case (r_addr)
          8'h01:   r_st1       <= i_bus_in;
          8'h21:   r_pend.seg  <= i_bus_in;
          8'h22:   r_pend.min  <= i_bus_in;
          8'h23:   r_pend.hora <= i_bus_in;
          8'h24:   r_pend.dia  <= i_bus_in;
          8'h25:   r_pend.mes  <= i_bus_in;
          8'h26:   r_pend.anio <= i_bus_in;
          default: ;
        endcase
      end
      // st0[2] is sticky: only a written 0 clears it
      if (w_st0_wr) {r_st0[7:3], r_st0[1:0]} <= {i_bus_in[7:3], i_bus_in[1:0]};
      r_st0[2] <= w_expire | (r_st0[2] & ~(w_st0_wr & ~i_bus_in[2]));
      if (w_st2_wr)      r_st2    <= i_bus_in;
      else if (w_expire) r_st2[0] <= 1'b0;
      r_bus_oe  <= w_rd_act;
      r_bus_out <= w_rd_act ? w_rd_data : 8'h00;
    end
  end

  assign o_bus_oe  = r_bus_oe;
  assign o_bus_out = r_bus_out;
endmodule

// File: tb/tb_rtc_bus_responder.sv
// Randomized bench for rtc_bus_responder against a decimal calendar/timer model.
module tb_rtc_bus_responder;
  localparam int S = 2;

  logic clk = 1'b0, reset = 1'b0, tick = 1'b0;
  logic cs = 1'b1, rd = 1'b1, wr = 1'b1, a_d = 1'b0;
  logic [7:0] bus_in = 8'h00, bus_out;
  logic bus_oe, irq;
  int n_err = 0, n_chk = 0;

  rtc_bus_responder #(.SYNC_STAGES(S)) dut (
    .i_clk(clk), .i_reset(reset), .i_tick_1hz(tick), .i_cs(cs), .i_rd(rd), .i_wr(wr),
    .i_a_d(a_d), .i_bus_in(bus_in), .o_bus_out(bus_out), .o_bus_oe(bus_oe), .o_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // model: index 0 sec,1 min,2 hour,3 day,4 month,5 year (decimal); timer in total seconds
  int lv[6], pd[6], sn[6];
  int tl, tp, ts;
  logic [7:0] m_st0, m_st1, m_st2;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction

  function automatic int mdays(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 6; i++) begin
      lv[i] = (i == 3 || i == 4) ? 1 : 0;
      pd[i] = lv[i];
      sn[i] = lv[i];
    end
    tl = 0; tp = 0; ts = 0;
    m_st0 = 8'h00; m_st1 = 8'h00; m_st2 = 8'h00;
  endfunction

  function automatic void m_tick(input bit do_time, input bit do_timer);
    if (do_time) begin
      lv[0]++;
      if (lv[0] == 60) begin
        lv[0] = 0; lv[1]++;
        if (lv[1] == 60) begin
          lv[1] = 0; lv[2]++;
          if (lv[2] == 24) begin
            lv[2] = 0; lv[3]++;
            if (lv[3] > mdays(lv[4], lv[5])) begin
              lv[3] = 1; lv[4]++;
              if (lv[4] == 13) begin lv[4] = 1; lv[5] = (lv[5] + 1) % 100; end
            end
          end
        end
      end
    end
`ifdef RTC_RESP_TIMER_EN
    if (do_timer && m_st2[0] && tl > 0) begin
      tl--;
      if (tl == 0) begin m_st0[2] = 1'b1; m_st2[0] = 1'b0; end
    end
`else
    if (do_timer) tl = 0;
`endif
  endfunction

  task automatic bus_write(input bit ad, input logic [7:0] v, input bit tick_at_evt);
    @(posedge clk); #1;
    cs = 1'b0; a_d = ad; bus_in = v; wr = 1'b0;
    repeat (S + 2) @(posedge clk); #1;
    wr = 1'b1;
    if (tick_at_evt) begin
      repeat (S) @(posedge clk); #1;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      repeat (2) @(posedge clk); #1;
    end else begin
      repeat (S + 3) @(posedge clk); #1;
    end
    cs = 1'b1;
  endtask

  task automatic wr_addr(input logic [7:0] a); bus_write(1'b0, a, 1'b0); endtask
  task automatic wr_data(input logic [7:0] d); bus_write(1'b1, d, 1'b0); endtask
  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d); wr_addr(a); wr_data(d); endtask

  task automatic do_tick();
    @(posedge clk); #1; tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    m_tick(1'b1, 1'b1);
  endtask

  task automatic read_cur(output logic o, output logic [7:0] d);
    @(posedge clk); #1; cs = 1'b0; a_d = 1'b1;
    repeat (S + 1) @(posedge clk); #1; rd = 1'b0;
    repeat (S + 3) @(posedge clk);
    @(negedge clk); o = bus_oe; d = bus_out;
    @(posedge clk); #1; rd = 1'b1;
    repeat (S + 2) @(posedge clk); #1; cs = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic o; logic [7:0] d;
    wr_addr(a);
    read_cur(o, d);
    chk({tag, "_oe"}, {7'h0, o}, 8'h01);
    chk(tag, d, exp);
  endtask

  task automatic commit_time();
    for (int i = 0; i < 6; i++) wr_reg(8'(8'h21 + i), bcd(pd[i]));
    wr_reg(8'hF1, 8'h00);
    lv = pd;
  endtask

  task automatic check_live(input string tag);
    wr_reg(8'hF0, 8'h00);
    sn = lv; ts = tl;
    for (int i = 0; i < 6; i++) rd_chk($sformatf("%s_t%0d", tag, i), 8'(8'h21 + i), bcd(sn[i]));
`ifdef RTC_RESP_TIMER_EN
    rd_chk({tag, "_tsec"}, 8'h41, bcd(ts % 60));
    rd_chk({tag, "_tmin"}, 8'h42, bcd((ts / 60) % 60));
    rd_chk({tag, "_thr"},  8'h43, bcd(ts / 3600));
`else
    rd_chk({tag, "_t41"}, 8'h41, 8'h00);
`endif
  endtask

`ifdef RTC_RESP_TIMER_EN
  task automatic set_timer(input int t);
    wr_reg(8'h41, bcd(t % 60));
    wr_reg(8'h42, bcd((t / 60) % 60));
    wr_reg(8'h43, bcd(t / 3600));
    tp = t;
  endtask
`endif

  initial begin
    logic o; logic [7:0] d; int n;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_oe", {7'h0, bus_oe}, 8'h00);
    chk("rst_out", bus_out, 8'h00);
    chk("rst_irq", {7'h0, irq}, 8'h00);
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_live("rstval");
    rd_chk("rst_st0", 8'h00, 8'h00);
    rd_chk("rst_st2", 8'h02, 8'h00);

    // address + data write, commit, snapshot, read back
    wr_reg(8'h22, 8'h45);
    pd[1] = 45;
    wr_reg(8'hF1, 8'h00); lv = pd;
    wr_reg(8'hF0, 8'h00);
    rd_chk("min45", 8'h22, 8'h45);

    // leap and non-leap February rollover
    pd = '{59, 59, 23, 28, 2, 24}; commit_time(); do_tick(); check_live("leap");
    pd = '{59, 59, 23, 28, 2, 23}; commit_time(); do_tick(); check_live("noleap");
    pd = '{59, 59, 23, 31, 12, 99}; commit_time(); do_tick(); check_live("century");

    // F1 commit in the same clk as a tick: committed value wins
    wr_reg(8'h21, 8'h10); pd[0] = 10;
    wr_addr(8'hF1);
    bus_write(1'b1, 8'h00, 1'b1);
    lv = pd; m_tick(1'b0, 1'b1);
    check_live("f1tick");
    do_tick(); check_live("f1after");

    // status registers
    m_st1 = 8'($urandom_range(0, 255));
    wr_reg(8'h01, m_st1); rd_chk("st1", 8'h01, m_st1);
    wr_reg(8'h00, 8'hFF); m_st0 = {8'hFF & 8'hFB} | (m_st0 & 8'h04);
    rd_chk("st0_w1", 8'h00, m_st0);
    wr_reg(8'h00, 8'h00); m_st0 = 8'h00;

    // read window timing on 0x21 with rd low 6 clks
    wr_addr(8'h21);
    @(posedge clk); #1; cs = 1'b0; a_d = 1'b1;
    repeat (S + 1) @(posedge clk); #1; rd = 1'b0;
    for (int k = 1; k <= 6 + S + 3; k++) begin
      @(posedge clk);
      if (k == 6) begin #1; rd = 1'b1; end
      @(negedge clk);
      chk($sformatf("rdwin%0d", k), {7'h0, bus_oe}, (k >= S + 1 && k <= 6 + S) ? 8'h01 : 8'h00);
      if (k == S + 1) chk("rdwin_data", bus_out, bcd(sn[0]));
    end
    @(posedge clk); #1; cs = 1'b1;
    rd_chk("unmap30", 8'h30, 8'h00);
    rd_chk("unmapF0", 8'hF0, 8'h00);

`ifdef RTC_RESP_TIMER_EN
    // countdown to expiry, sticky irq, ignored ticks at zero
    set_timer(2); wr_reg(8'hF2, 8'h00); tl = tp;
    wr_reg(8'h02, 8'h01); m_st2 = 8'h01;
    for (int i = 0; i < 3; i++) begin
      do_tick(); @(negedge clk);
      chk($sformatf("tmr_irq%0d", i), {7'h0, irq}, {7'h0, m_st0[2]});
    end
    rd_chk("tmr_st2", 8'h02, m_st2);
    check_live("tmr0");
    wr_reg(8'h00, 8'h04); @(negedge clk);
    chk("irq_w1", {7'h0, irq}, 8'h01);
    wr_reg(8'h00, 8'h00); m_st0 = 8'h00; @(negedge clk);
    chk("irq_clr", {7'h0, irq}, 8'h00);

    // F2 commit in the same clk as a tick: timer takes committed value, time still advances
    set_timer(30); wr_reg(8'hF2, 8'h00); tl = tp;
    wr_reg(8'h02, 8'h01); m_st2 = 8'h01;
    do_tick();
    set_timer(45);
    wr_addr(8'hF2);
    bus_write(1'b1, 8'h00, 1'b1);
    tl = tp; m_tick(1'b1, 1'b0);
    check_live("f2tick");

    for (int it = 0; it < 8; it++) begin
      int t;
      t = int'($urandom_range(1, 150));
      set_timer(t); wr_reg(8'hF2, 8'h00); tl = tp;
      wr_reg(8'h02, 8'h01); m_st2 = 8'h01;
      n = ($urandom_range(0, 1) == 1) ? t + int'($urandom_range(0, 2)) : int'($urandom_range(0, t));
      repeat (n) do_tick();
      @(negedge clk);
      chk($sformatf("rtmr_irq%0d", it), {7'h0, irq}, {7'h0, m_st0[2]});
      rd_chk($sformatf("rtmr_st2_%0d", it), 8'h02, m_st2);
      check_live($sformatf("rtmr%0d", it));
      wr_reg(8'h00, 8'h00); m_st0 = 8'h00;
      wr_reg(8'h02, 8'h00); m_st2 = 8'h00;
    end
`else
    // timer features absent: writes ignored, irq tied low
    wr_reg(8'h41, 8'h12); wr_reg(8'hF2, 8'h00);
    wr_reg(8'h02, 8'h01); m_st2 = 8'h01;
    repeat (3) do_tick();
    @(negedge clk);
    chk("notmr_irq", {7'h0, irq}, 8'h00);
    rd_chk("notmr_st0", 8'h00, 8'h00);
    check_live("notmr");
`endif

    // randomized calendar rollovers
    for (int it = 0; it < 16; it++) begin
      pd[5] = int'($urandom_range(0, 99));
      pd[4] = int'($urandom_range(1, 12));
      if (it % 4 == 3) begin
        pd[3] = int'($urandom_range(1, mdays(pd[4], pd[5])));
        pd[2] = int'($urandom_range(0, 23));
        pd[1] = int'($urandom_range(0, 59));
        pd[0] = int'($urandom_range(0, 59));
      end else begin
        pd[3] = mdays(pd[4], pd[5]) - int'($urandom_range(0, 1));
        pd[2] = 23 - int'($urandom_range(0, 1));
        pd[1] = 59 - int'($urandom_range(0, 1));
        pd[0] = 59 - int'($urandom_range(0, 3));
      end
      commit_time();
      n = int'($urandom_range(1, 6));
      repeat (n) do_tick();
      check_live($sformatf("rnd%0d", it));
    end

    // reset during an active read, with wr held low across release
    wr_reg(8'h01, 8'hA5);
    wr_addr(8'h01);
    @(posedge clk); #1; cs = 1'b0; a_d = 1'b1;
    repeat (S + 1) @(posedge clk); #1; rd = 1'b0;
    repeat (S + 3) @(posedge clk);
    @(negedge clk);
    chk("mid_oe_pre", {7'h0, bus_oe}, 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("mid_oe", {7'h0, bus_oe}, 8'h00);
    chk("mid_out", bus_out, 8'h00);
    rd = 1'b1; wr = 1'b0; cs = 1'b0; a_d = 1'b1; bus_in = 8'h5A;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    repeat (S + 4) @(posedge clk); #1; wr = 1'b1;
    repeat (S + 4) @(posedge clk); #1; cs = 1'b1;
    read_cur(o, d);
    chk("rel_nowr_oe", {7'h0, o}, 8'h01);
    chk("rel_nowr", d, 8'h00);
    rd_chk("post_st1", 8'h01, 8'h00);
    rd_chk("post_st2", 8'h02, 8'h00);
    wr_reg(8'hF1, 8'h00); lv = pd;
    check_live("postrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rtc_bus_responder.md
RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on cs/rd/wr/a_d; legal values are 2..4.
REQ-002 clk  input  1  single system clock; every flop is clocked on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 tick_1hz  input  1  one-clk pulse per second, synchronous to clk.
REQ-005 cs, rd, wr  input  1 each  active-low bus chip select, read strobe and write strobe.
REQ-006 a_d  input  1  bus phase select: 0 = address phase, 1 = data phase.
REQ-007 bus_in  input  8  bus value driven by the controller.
REQ-008 bus_out  output  8  read data.
REQ-009 bus_oe  output  1  high while the responder drives the bus.
REQ-010 irq  output  1  timer-expired flag, high while status bit st0[2] is set.

Function
REQ-011 cs, rd, wr and a_d shall each pass through a SYNC_STAGES-flop synchronizer; all later rules use the synchronized values.
REQ-012 Write event: a synchronized rising edge of wr with cs low; one event per edge.
REQ-013 On a write event with a_d=0, addr[7:0] shall load bus_in.
REQ-014 On a write event with a_d=1, the register at addr shall load bus_in.
  - Map: st0 0x00, st1 0x01, st2 0x02; seg 0x21, min 0x22, hora 0x23, dia 0x24, mes 0x25, anio 0x26; tseg 0x41, tmin 0x42, thora 0x43.
  - Time and timer writes go to a pending bank; status writes take effect immediately.
  - Writes to unmapped addresses are ignored.
REQ-015 A write event with a_d=1 at one of the command addresses shall trigger a transfer; bus_in is ignored.
  - 0xF0: copy live time and live timer into the read snapshot.
  - 0xF1: copy pending time into live time.
  - 0xF2: copy pending timer into live timer.
REQ-016 Read: while synchronized cs=0, rd=0 and a_d=1, bus_oe=1 and bus_out shows the registered snapshot or status value at addr.
  - Unmapped addresses read 0x00.
  - Otherwise bus_oe=0 and bus_out=0x00.
REQ-017 Read latency: bus_oe rises SYNC_STAGES+1 clks after the rd pin falls; the controller holds rd low at least SYNC_STAGES+3 clks.
REQ-018 On each tick_1hz, live time shall advance in packed BCD.
  - seg and min wrap 59->00 with carry; hora wraps 23->00 with carry.
  - dia wraps at the end of the month: 31, 30, or 28/29 for February, with 29 when the BCD anio is divisible by 4.
  - mes wraps 12->01 with carry; anio wraps 99->00.
REQ-019 Timer countdown, when st2[0]=1:
  - each tick decrements thora:tmin:tseg in BCD, with tseg/tmin borrowing 00->59;
  - when 00:00:00 is reached, st0[2] is set, st2[0] is cleared and counting stops;
  - a tick at 00:00:00 is ignored.
REQ-020 Writing 0 to st0[2] clears irq; writing 1 has no effect.
REQ-021 An F1/F2 commit in the same clk as tick_1hz wins: the committed value is loaded unchanged and that tick is dropped for that bank only.
REQ-022 An address write and a tick in the same clk shall both take effect.
REQ-023 Pending-bank values are not range-checked; counting continues from whatever value was committed, using the carry rules.

Reset
REQ-024 While reset=0, every flop shall clear asynchronously.
  - Synchronizers clear to the idle level 1.
  - addr=0x00; all status registers 0x00.
  - Live, pending and snapshot banks: seg/min/hora 00, dia 01, mes 01, anio 00, all timer fields 00.
  - bus_oe=0, bus_out=0x00, irq=0.
REQ-025 Reset asserted mid-read shall drop bus_oe to 0 asynchronously.
REQ-026 After release, no write event shall be detected until wr has been seen high and then low at the synchronized level.

Configuration
REQ-027 With macro RTC_RESP_TIMER_EN defined, the timer bank, F2 command, countdown, st0[2] and irq shall be implemented.
REQ-028 Without RTC_RESP_TIMER_EN:
  - 0x41-0x43 read 0x00 and their writes are ignored;
  - 0xF2 is ignored;
  - st0[2] reads 0 and irq is tied 0.

Verification
REQ-029 Write addr 0x22 then data 0x45, write addr 0xF1 with a data strobe, write 0xF0, read 0x22 -> bus_out=0x45.
REQ-030 Live time 23:59:59, dia 28, mes 02, anio 24, then one tick -> 00:00:00, dia 29, mes 02; repeat with anio 23 -> dia 01, mes 03.
REQ-031 Timer 00:00:02 via F2, st2=0x01, three ticks -> irq=1 after the second tick, st2 reads 0x00, timer stays 00:00:00; write st0=0x00 -> irq=0.
REQ-032 Pulse F1 commit (pending seg=0x10) in the same clk as tick_1hz -> live seg=0x10, not 0x11.
REQ-033 Read 0x21 with rd low for 6 clks -> bus_oe high exactly from clk SYNC_STAGES+1 until rd rises; reading unmapped 0x30 -> 0x00.
REQ-034 Assert reset during an active read -> bus_oe=0 immediately and all registers return to their reset values.
